// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Instruction-cycle controller for the Gumnut program-counter unit.
//            Steps each instruction through FETCH -> DECODE -> EXEC, with an
//            optional WAIT stall and a one-cycle INT entry. It is the only
//            driver of the PC control strobes. It also owns the
//            interrupt-enable flag and the interrupt request/ack handshake.
// Ports    : clk, rst (sync, active-high), cen (clock enable)
//            inst_ack_i, data_ack_i      bus acknowledges
//            op_i, cond_i, misc_i        decoded instruction fields
//            int_req                     level interrupt request
//            inst_stb_o, data_stb_o      bus strobes
//            PCEn_c, PCoper_c            PC write enable / next-PC operation
//            push_c, pop_c, int_c        return stack / IntReg controls
//            int_ack, ie_o, illegal_o    interrupt ack, IE flag, illegal pulse
//            stk_ovf_o, stk_unf_o        sticky return-stack error flags
// Options  : define STACK_CHECK_EN to track return-stack occupancy
//            (STACK_DEPTH entries) and suppress over/underflowing push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       inst_ack_i,
  input  logic       data_ack_i,
  input  logic [2:0] op_i,
  input  logic [1:0] cond_i,
  input  logic [2:0] misc_i,
  input  logic       int_req,
  output logic       inst_stb_o,
  output logic       data_stb_o,
  output logic       PCEn_c,
  output logic [3:0] PCoper_c,
  output logic       push_c,
  output logic       pop_c,
  output logic       int_c,
  output logic       int_ack,
  output logic       ie_o,
  output logic       illegal_o,
  output logic       stk_ovf_o,
  output logic       stk_unf_o
);

  // Decoded instruction classes
  localparam logic [2:0] c_OP_MEM    = 3'd1;
  localparam logic [2:0] c_OP_JMP    = 3'd2;
  localparam logic [2:0] c_OP_JSB    = 3'd3;
  localparam logic [2:0] c_OP_BRANCH = 3'd4;
  localparam logic [2:0] c_OP_MISC   = 3'd5;
  localparam logic [2:0] c_OP_ILL6   = 3'd6;
  localparam logic [2:0] c_OP_ILL7   = 3'd7;

  // MISC sub-operations
  localparam logic [2:0] c_MISC_RET  = 3'd0;
  localparam logic [2:0] c_MISC_RETI = 3'd1;
  localparam logic [2:0] c_MISC_ENAI = 3'd2;
  localparam logic [2:0] c_MISC_DISI = 3'd3;
  localparam logic [2:0] c_MISC_WAIT = 3'd4;

  // Next-PC operation codes
  localparam logic [3:0] c_PC_INC  = 4'd0;
  localparam logic [3:0] c_PC_BZ   = 4'd1;
  localparam logic [3:0] c_PC_JMP  = 4'd5;
  localparam logic [3:0] c_PC_JSB  = 4'd6;
  localparam logic [3:0] c_PC_RET  = 4'd7;
  localparam logic [3:0] c_PC_RETI = 4'd8;
  localparam logic [3:0] c_PC_INT  = 4'd9;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WAIT   = 3'd3,
    S_INT    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       ie_q, ie_d;
  logic       stk_ovf_q, stk_ovf_d;
  logic       stk_unf_q, stk_unf_d;

  logic       w_stk_full;
  logic       w_stk_empty;

  logic       w_inst_stb;
  logic       w_data_stb;
  logic       w_pcen;
  logic [3:0] w_oper;
  logic       w_push;
  logic       w_pop;
  logic       w_int_c;
  logic       w_int_ack;
  logic       w_illegal;
  logic       w_done;

`ifdef STACK_CHECK_EN
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign w_stk_full  = (cnt_q == CW'(STACK_DEPTH));
  assign w_stk_empty = (cnt_q == '0);

  // Only pushes/pops actually issued move the occupancy count.
  always_comb begin
    cnt_d = cnt_q;
    if (w_push) begin
      cnt_d = cnt_q + CW'(1);
    end else if (w_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end
`else
  // Without occupancy tracking the stack can never be reported full/empty.
  assign w_stk_full  = (STACK_DEPTH < 0);
  assign w_stk_empty = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    stk_ovf_d  = stk_ovf_q;
    stk_unf_d  = stk_unf_q;
    w_inst_stb = 1'b0;
    w_data_stb = 1'b0;
    w_pcen     = 1'b0;
    w_oper     = c_PC_INC;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_int_c    = 1'b0;
    w_int_ack  = 1'b0;
    w_illegal  = 1'b0;
    w_done     = 1'b0;

    case (state_q)
      S_FETCH: begin
        w_inst_stb = 1'b1;
        if (inst_ack_i) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        w_done = 1'b1;
        w_pcen = 1'b1;
        case (op_i)
          c_OP_MEM: begin
            w_data_stb = 1'b1;
            w_done     = data_ack_i;
            w_pcen     = data_ack_i;
          end
          c_OP_JMP: begin
            w_oper = c_PC_JMP;
          end
          c_OP_JSB: begin
            // A push into a full stack is dropped and falls through as INC.
            if (w_stk_full) begin
              stk_ovf_d = 1'b1;
            end else begin
              w_oper = c_PC_JSB;
              w_push = 1'b1;
            end
          end
          c_OP_BRANCH: begin
            // Condition is resolved downstream; we only select which test.
            w_oper = c_PC_BZ + {2'b00, cond_i};
          end
          c_OP_MISC: begin
            case (misc_i)
              c_MISC_RET: begin
                if (w_stk_empty) begin
                  stk_unf_d = 1'b1;
                end else begin
                  w_oper = c_PC_RET;
                  w_pop  = 1'b1;
                end
              end
              c_MISC_RETI: begin
                // Return address comes from IntReg, not the return stack.
                w_oper = c_PC_RETI;
                ie_d   = 1'b1;
              end
              c_MISC_ENAI: ie_d = 1'b1;
              c_MISC_DISI: ie_d = 1'b0;
              default: ;
            endcase
          end
          c_OP_ILL6, c_OP_ILL7: begin
            w_illegal = 1'b1;
          end
          default: ;
        endcase

        // Interrupt decision uses the IE value this instruction leaves behind,
        // so ENAI takes a pending request at once and DISI blocks it.
        if (w_done) begin
          if (op_i == c_OP_MISC && misc_i == c_MISC_WAIT) begin
            state_d = S_WAIT;
          end else if (int_req && ie_d) begin
            state_d = S_INT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_WAIT: begin
        // A request with interrupts disabled still wakes the core up.
        if (int_req) begin
          state_d = ie_q ? S_INT : S_FETCH;
        end
      end

      S_INT: begin
        w_int_c   = 1'b1;
        w_pcen    = 1'b1;
        w_oper    = c_PC_INT;
        w_int_ack = 1'b1;
        ie_d      = 1'b0;
        state_d   = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ie_q      <= 1'b0;
      stk_ovf_q <= 1'b0;
      stk_unf_q <= 1'b0;
`ifdef STACK_CHECK_EN
      cnt_q     <= '0;
`endif
    end else if (cen) begin
      state_q   <= state_d;
      ie_q      <= ie_d;
      stk_ovf_q <= stk_ovf_d;
      stk_unf_q <= stk_unf_d;
`ifdef STACK_CHECK_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Every output is forced low while reset is asserted.
  assign inst_stb_o = ~rst & w_inst_stb;
  assign data_stb_o = ~rst & w_data_stb;
  assign PCEn_c     = ~rst & w_pcen;
  assign PCoper_c   = (rst || !w_pcen) ? c_PC_INC : w_oper;
  assign push_c     = ~rst & w_push;
  assign pop_c      = ~rst & w_pop;
  assign int_c      = ~rst & w_int_c;
  assign int_ack    = ~rst & w_int_ack;
  assign ie_o       = ~rst & ie_q;
  assign illegal_o  = ~rst & w_illegal;
  assign stk_ovf_o  = ~rst & stk_ovf_q;
  assign stk_unf_o  = ~rst & stk_unf_q;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-cycle controller for the Gumnut program-counter unit; sole driver of its control strobes: PCEn_c, PCoper_c, push_c, pop_c, int_c.
- Sequences fetch, decode, execute, interrupt entry and WAIT.
- Owns the interrupt-enable flag and the interrupt request/acknowledge handshake.
- Optionally tracks return-stack occupancy.

Parameters:
STACK_DEPTH, 8, return-stack entries; used only with STACK_CHECK_EN.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cen  in  1  clock enable; all state updates qualified by cen
inst_ack_i  in  1  instruction bus acknowledge
data_ack_i  in  1  data bus acknowledge
op_i  in  3  decoded class: 0 ALU, 1 MEM, 2 JMP, 3 JSB, 4 BRANCH, 5 MISC, 6-7 illegal
cond_i  in  2  branch condition: 0 BZ, 1 BNZ, 2 BC, 3 BNC
misc_i  in  3  MISC subop: 0 RET, 1 RETI, 2 ENAI, 3 DISI, 4 WAIT, 5-7 NOP
int_req  in  1  interrupt request, level
inst_stb_o  out  1  instruction fetch strobe
data_stb_o  out  1  data access strobe
PCEn_c  out  1  PC write enable
PCoper_c  out  4  next-PC operation
push_c  out  1  stack push
pop_c  out  1  stack pop
int_c  out  1  IntReg capture (PC, carry, zero)
int_ack  out  1  interrupt acknowledge pulse
ie_o  out  1  interrupt-enable flag
illegal_o  out  1  illegal-op pulse
stk_ovf_o  out  1  sticky stack overflow
stk_unf_o  out  1  sticky stack underflow

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset:
  - state=FETCH, ie=0, stack count=0, sticky flags=0.
  - While rst=1, all outputs are 0.
  - Reset mid-operation abandons any bus cycle; FETCH begins on the first cycle after rst falls.
- cen=0: state, ie, count and sticky flags hold. Outputs stay stable, being a decode of the held state and inputs.
- PCoper_c codes: INC 0, BZ 1, BNZ 2, BC 3, BNC 4, JMP 5, JSB 6, RET 7, RETI 8, INT 9. PCoper_c=0 when PCEn_c=0.
- FETCH:
  - inst_stb_o=1.
  - Leaves on the first cen cycle with inst_ack_i=1 -> DECODE.
- DECODE: one cycle; all strobes 0 -> EXEC.
- EXEC:
  - MEM: data_stb_o=1 until data_ack_i. On the ack cycle, PCEn_c=1 with INC.
  - Every other op completes in one cycle with PCEn_c=1:
    - ALU, ENAI, DISI, NOP, illegal: INC.
    - JMP: JMP.
    - JSB: JSB plus push_c=1.
    - BRANCH: code 1+cond_i (condition evaluated downstream).
    - RET: RET plus pop_c=1.
    - RETI: RETI plus pop_c=0.
    - WAIT: INC.
  - Flag effects on the completing cycle: ENAI sets ie; DISI clears ie; RETI sets ie.
  - Illegal op: pulses illegal_o for 1 cycle.
  - Next state: WAIT op -> WAIT; else INT if int_req&ie, evaluated with the post-instruction ie; else FETCH.
- WAIT:
  - All strobes 0.
  - int_req&ie -> INT.
  - int_req&!ie -> FETCH.
  - Otherwise stay.
- INT: one cycle.
  - int_c=1, PCEn_c=1, PCoper_c=INT, int_ack=1.
  - ie cleared.
  - -> FETCH.
  - Nested interrupts are impossible until RETI/ENAI.
- Latency: minimum 3 cycles per non-MEM instruction with immediate ack. Interrupt entry adds 1 cycle.
- Simultaneous ENAI and int_req: interrupt is taken immediately after ENAI. DISI with int_req: not taken.

Optional Feature:
- STACK_CHECK_EN defined:
  - Counter 0..STACK_DEPTH: +1 on issued push, -1 on issued pop.
  - JSB at count==STACK_DEPTH: push_c=0, PCoper_c=INC, stk_ovf_o set sticky.
  - RET at count==0: pop_c=0, PCoper_c=INC, stk_unf_o set sticky.
  - Sticky flags clear only on rst.
- Undefined: no counter; push/pop always issued; stk_ovf_o=stk_unf_o=0.

Test Plan:
- Reset then ALU op, inst_ack_i at 2nd FETCH cycle -> inst_stb_o high 2 cycles, DECODE, EXEC PCEn_c=1 PCoper_c=0, back to FETCH; 4 cycles total.
- MEM op, data_ack_i after 3 wait cycles -> data_stb_o high 4 cycles, PCEn_c only on ack cycle; cen=0 for 2 cycles mid-access -> state held, completion delayed 2 cycles.
- ENAI then int_req=1 -> ie_o=1 after EXEC, INT cycle with int_c=int_ack=1 PCoper_c=9, ie_o=0; later RETI -> PCoper_c=8, pop_c=0, ie_o=1.
- WAIT with ie=0, int_req raised after 5 cycles -> stays in WAIT 5 cycles, then FETCH, no int_ack; same with ie=1 -> INT.
- STACK_CHECK_EN, STACK_DEPTH=2: three JSB -> push_c on first two, third gives PCoper_c=0 and stk_ovf_o=1; three RET -> pop_c twice, third sets stk_unf_o.
- op_i=6 -> illegal_o 1-cycle pulse, PCoper_c=0; rst asserted during FETCH with pending ack -> outputs 0, clean FETCH after release.
